// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } own_state_t;

    localparam logic TAG_I = 1'b0;
    localparam logic TAG_D = 1'b1;

    // Bank select lives in word-address bits [2:1].
    localparam int BANK_LO = 1;
    localparam int BANK_HI = 2;

endpackage

// File: rtl/mem_arbiter_rd_return_pipe.sv
// RD_LAT-deep (valid, owner) shift register that steers returning memory
// read data to the cache controller that issued the read.
module rd_return_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_owner,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ic_rdata,
    output logic          ic_rvalid,
    output logic [DW-1:0] dc_rdata,
    output logic          dc_rvalid
);

    logic [RD_LAT-1:0] vld_reg;
    logic [RD_LAT-1:0] own_reg;
    logic [RD_LAT-1:0] vld_next;
    logic [RD_LAT-1:0] own_next;
    logic              tail_valid;
    logic              tail_owner;

    assign vld_next[0] = issue_valid;
    assign own_next[0] = issue_owner;

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
            assign vld_next[gi] = vld_reg[gi-1];
            assign own_next[gi] = own_reg[gi-1];
        end
    endgenerate

    // Reset drops every in-flight tag, so data arriving afterwards is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
            own_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            own_reg <= own_next;
        end
    end

    assign tail_valid = vld_reg[RD_LAT-1];
    assign tail_owner = own_reg[RD_LAT-1];

    assign ic_rvalid = tail_valid && (tail_owner == TAG_I);
    assign dc_rvalid = tail_valid && (tail_owner == TAG_D);
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the four-bank main memory between I-cache and D-cache with bank
// busy checks, bus locking and read-return steering. MEM_ARB_RR_EN selects round-robin tie-break.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ic_rd,
    input  logic          ic_lock,
    input  logic [AW-1:0] ic_addr,
    output logic          ic_gnt,
    output logic [DW-1:0] ic_rdata,
    output logic          ic_rvalid,
    input  logic          dc_rd,
    input  logic          dc_wr,
    input  logic          dc_lock,
    input  logic [AW-1:0] dc_addr,
    input  logic [DW-1:0] dc_wdata,
    output logic          dc_gnt,
    output logic [DW-1:0] dc_rdata,
    output logic          dc_rvalid,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic [3:0]    mem_busy,
    input  logic          mem_stall,
    input  logic          mem_err,
    output logic          err
);

    own_state_t state_reg;
    own_state_t state_next;
    logic       ic_elig;
    logic       dc_elig;
    logic       dc_conflict;
    logic       tie_to_d;
    logic       err_reg;

    // A simultaneous read+write from the D-cache is malformed and never granted.
    assign dc_conflict = dc_rd && dc_wr;
    assign ic_elig = ic_rd && !mem_stall && !mem_busy[ic_addr[BANK_HI:BANK_LO]];
    assign dc_elig = (dc_rd || dc_wr) && !dc_conflict && !mem_stall
                     && !mem_busy[dc_addr[BANK_HI:BANK_LO]];

`ifdef MEM_ARB_RR_EN
    logic last_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_reg <= TAG_I;
        end else if (ic_gnt || dc_gnt) begin
            last_d_reg <= dc_gnt;
        end
    end

    assign tie_to_d = (last_d_reg == TAG_I);
`else
    assign tie_to_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        ic_gnt     = 1'b0;
        dc_gnt     = 1'b0;
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ic_elig && dc_elig) begin
                    dc_gnt = tie_to_d;
                    ic_gnt = !tie_to_d;
                end else begin
                    ic_gnt = ic_elig;
                    dc_gnt = dc_elig;
                end
                if (ic_gnt && ic_lock) begin
                    state_next = OWN_I;
                end else if (dc_gnt && dc_lock) begin
                    state_next = OWN_D;
                end
            end
            // The owner may still be granted in the cycle it drops its lock.
            OWN_I: begin
                ic_gnt = ic_elig;
                if (!ic_lock) begin
                    state_next = IDLE;
                end
            end
            OWN_D: begin
                dc_gnt = dc_elig;
                if (!dc_lock) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_rd    = ic_gnt || (dc_gnt && dc_rd);
    assign mem_wr    = dc_gnt && dc_wr;
    assign mem_addr  = ic_gnt ? ic_addr : (dc_gnt ? dc_addr : '0);
    assign mem_wdata = dc_gnt ? dc_wdata : '0;

    // An error during an in-flight read is also signalled on mem_err, so one term covers both.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (mem_err || dc_conflict) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

    rd_return_pipe #(
        .RD_LAT (RD_LAT),
        .DW     (DW)
    ) u_rd_return_pipe (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (mem_rd),
        .issue_owner (dc_gnt ? TAG_D : TAG_I),
        .mem_rdata   (mem_rdata),
        .ic_rdata    (ic_rdata),
        .ic_rvalid   (ic_rvalid),
        .dc_rdata    (dc_rdata),
        .dc_rvalid   (dc_rvalid)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic
// compared cycle by cycle against a behavioural arbitration model.
module tb_mem_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_rd = 1'b0, ic_lock = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          dc_rd = 1'b0, dc_wr = 1'b0, dc_lock = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic [3:0]    mem_busy = '0;
    logic          mem_stall = 1'b0, mem_err = 1'b0;
    logic          ic_gnt, ic_rvalid, dc_gnt, dc_rvalid, mem_rd, mem_wr, err;
    logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .ic_rd(ic_rd), .ic_lock(ic_lock), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
        .dc_rd(dc_rd), .dc_wr(dc_wr), .dc_lock(dc_lock), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_gnt(dc_gnt), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_stall(mem_stall),
        .mem_err(mem_err), .err(err)
    );

    typedef struct {
        bit          chk;
        bit          gi;
        bit          gd;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          err;
    } exp_t;

    typedef struct {
        bit to_d;
        int due;
    } ret_t;

    exp_t exp_q[$];
    ret_t ret_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    // Reference model state: 0 = nobody owns the bus, 1 = I-cache, 2 = D-cache.
    int   owner_m  = 0;
    bit   last_d_m = 1'b0;
    bit   err_m    = 1'b0;

    function automatic logic [15:0] data_of(input int c);
        return 16'(c * 40503 + 7);
    endfunction

    task automatic step(input bit r, input bit ird, input bit ilk, input logic [15:0] ia,
                        input bit drd, input bit dwr, input bit dlk, input logic [15:0] da,
                        input logic [15:0] wd, input logic [3:0] bsy, input bit stl,
                        input bit me);
        exp_t e;
        bit   ei, ed, wi, wdg;
        @(negedge clk);
        cyc++;
        rst = r; ic_rd = ird; ic_lock = ilk; ic_addr = ia;
        dc_rd = drd; dc_wr = dwr; dc_lock = dlk; dc_addr = da; dc_wdata = wd;
        mem_busy = bsy; mem_stall = stl; mem_err = me; mem_rdata = data_of(cyc);
        #1;
        e = '{default: '0};
        e.chk = !r;
        e.err = err_m;
        if (r) begin
            owner_m  = 0;
            last_d_m = 1'b0;
            err_m    = 1'b0;
            ret_q.delete();
        end else begin
            ei = ird && !stl && !bsy[int'(ia[2:1])] && (owner_m != 2);
            ed = (drd != dwr) && !stl && !bsy[int'(da[2:1])] && (owner_m != 1);
            wi  = 1'b0;
            wdg = 1'b0;
            if (ei && ed) begin
`ifdef MEM_ARB_RR_EN
                if (last_d_m) wi = 1'b1; else wdg = 1'b1;
`else
                wdg = 1'b1;
`endif
            end else begin
                wi  = ei;
                wdg = ed;
            end
            e.gi    = wi;
            e.gd    = wdg;
            e.rd    = wi || (wdg && drd);
            e.wr    = wdg && dwr;
            e.addr  = wi ? ia : (wdg ? da : 16'h0);
            e.wdata = wdg ? wd : 16'h0;
            if (e.rd) ret_q.push_back('{to_d: wdg, due: cyc + RD_LAT});
            if (owner_m == 0) begin
                if (wi && ilk) owner_m = 1;
                else if (wdg && dlk) owner_m = 2;
            end else if ((owner_m == 1 && !ilk) || (owner_m == 2 && !dlk)) begin
                owner_m = 0;
            end
            if (wi || wdg) last_d_m = wdg;
            if (me || (drd && dwr)) err_m = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
    endtask

    // Monitor: pops one expectation per cycle and checks grants, bus, error and returns.
    initial begin
        exp_t        e;
        ret_t        rt;
        bit          exp_r;
        bit          xi, xd;
        logic [15:0] xid, xdd;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if ({ic_gnt, dc_gnt} !== {e.gi, e.gd}) begin
                        errors++;
                        $display("FAIL gnt cyc=%0d got i=%b d=%b want i=%b d=%b",
                                 cyc, ic_gnt, dc_gnt, e.gi, e.gd);
                    end
                    checks++;
                    if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== {e.rd, e.wr, e.addr, e.wdata}) begin
                        errors++;
                        $display("FAIL membus cyc=%0d got rd=%b wr=%b a=%h wd=%h want rd=%b wr=%b a=%h wd=%h",
                                 cyc, mem_rd, mem_wr, mem_addr, mem_wdata, e.rd, e.wr, e.addr, e.wdata);
                    end
                    checks++;
                    if (err !== e.err) begin
                        errors++;
                        $display("FAIL err cyc=%0d got %b want %b", cyc, err, e.err);
                    end
                    exp_r = (ret_q.size() > 0) && (ret_q[0].due == cyc);
                    rt = '{to_d: 1'b0, due: 0};
                    if (exp_r) rt = ret_q.pop_front();
                    xi  = exp_r && !rt.to_d;
                    xd  = exp_r && rt.to_d;
                    xid = xi ? data_of(cyc) : 16'h0;
                    xdd = xd ? data_of(cyc) : 16'h0;
                    checks++;
                    if ({ic_rvalid, ic_rdata, dc_rvalid, dc_rdata} !== {xi, xid, xd, xdd}) begin
                        errors++;
                        $display("FAIL rret cyc=%0d got iv=%b id=%h dv=%b dd=%h want iv=%b id=%h dv=%b dd=%h",
                                 cyc, ic_rvalid, ic_rdata, dc_rvalid, dc_rdata, xi, xid, xd, xdd);
                    end
                    if (e.gi || e.gd)
                        $display("cyc=%0d grant %s rd=%b wr=%b addr=%h", cyc, e.gi ? "I" : "D", e.rd, e.wr, e.addr);
                    if (exp_r)
                        $display("cyc=%0d return %s data=%h", cyc, rt.to_d ? "D" : "I", data_of(cyc));
                end
            end
        end
    end

    initial begin
        bit          r, ird, ilk, drd, dwr, dlk, stl, me;
        logic [3:0]  bsy;
        int          k;
        // Reset and quiet bus
        step(1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        step(1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        idle(1);
        // D-cache read to bank 1, data returns two cycles later
        step(0, 0, 0, 16'h0, 1, 0, 0, 16'h0002, 16'h0, 4'h0, 0, 0);
        idle(3);
        // Three tie cycles on different banks
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0004, 16'h0, 4'h0, 0, 0);
        idle(3);
        // I-cache blocked by busy bank 0 while D-cache to bank 2 proceeds
        step(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0004, 16'h0, 4'b0001, 0, 0);
        step(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h0, 4'b0001, 0, 0);
        step(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h0, 4'b0000, 0, 0);
        idle(3);
        // Locked D-cache write-back then fill; I-cache waits until lock is released
        step(0, 1, 0, 16'h0010, 0, 1, 1, 16'h0006, 16'h1234, 4'h0, 0, 0);
        step(0, 1, 0, 16'h0010, 1, 0, 1, 16'h0006, 16'h0, 4'h0, 0, 0);
        step(0, 1, 0, 16'h0010, 0, 0, 0, 16'h0006, 16'h0, 4'h0, 0, 0);
        step(0, 1, 0, 16'h0010, 0, 0, 0, 16'h0006, 16'h0, 4'h0, 0, 0);
        idle(3);
        // Malformed read+write sets sticky error, cleared by a reset pulse
        step(0, 0, 0, 16'h0, 1, 1, 0, 16'h0002, 16'h5555, 4'h0, 0, 0);
        idle(3);
        step(1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        idle(2);
        // Read then reset before its data returns
        step(0, 1, 0, 16'h0008, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        step(1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        idle(3);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            ird = !r && ($urandom_range(0, 99) < 60);
            ilk = ($urandom_range(0, 99) < 30);
            k   = $urandom_range(0, 99);
            drd = !r && ((k < 30) || (k == 99));
            dwr = !r && ((k >= 30 && k < 55) || (k == 99));
            dlk = ($urandom_range(0, 99) < 30);
            for (int b = 0; b < 4; b++) bsy[b] = ($urandom_range(0, 3) == 0);
            stl = ($urandom_range(0, 9) == 0);
            me  = ($urandom_range(0, 199) == 0);
            step(r, ird, ilk, 16'($urandom), drd, dwr, dlk, 16'($urandom), 16'($urandom), bsy, stl, me);
        end
        idle(4);
        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
